bcd_counter_display: RTL

BCD_COUNTER_DISPLAY -- requirements
Module: bcd_counter_display

---
 rtl/bcd_counter_display.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/bcd_counter_display.sv
// rtl/bcd_counter_display.sv - push-button BCD up/down counter with 7-segment decode
// Optional input debounce is enabled by defining COUNTER_DEBOUNCE_EN.
`timescale 1ns/1ps

module bcd_counter_display #(
  parameter int                  DIGITS      = 6,
  parameter logic [4*DIGITS-1:0] START_VALUE = 24'h000019,
  parameter bit                  WRAP        = 1'b0,
  parameter int                  DB_CYCLES   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  zero,
  output logic                  at_max
);

  if (DIGITS < 1 || DIGITS > 8 || DB_CYCLES < 1 || DB_CYCLES > 65536) begin : g_param_check
    $error("bcd_counter_display: DIGITS or DB_CYCLES out of range");
  end

  typedef enum logic {
    WAIT_PRESS   = 1'b0,
    WAIT_RELEASE = 1'b1
  } btn_state_t;

  logic [1:0]    sync_q;
  logic [1:0]    sync_vld;
  logic          btn_sync;
  logic          btn_qual;
  logic          low_seen;
  btn_state_t    state;
  btn_state_t    state_next;
  logic          step;

  logic [4*DIGITS-1:0] inc_val;
  logic [4*DIGITS-1:0] dec_val;
  logic [4*DIGITS-1:0] load_clamped;
  logic                inc_carry;
  logic                dec_borrow;
  logic [3:0]          digit;
  logic [3:0]          ld_digit;

  // sync_vld marks when sync_q holds real samples of btn rather than reset zeros
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      sync_vld <= '0;
    end else begin
      sync_q   <= {sync_q[0], btn};
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  assign btn_sync = sync_q[1];

`ifdef COUNTER_DEBOUNCE_EN
  localparam int            CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] db_cnt;
  logic          db_level;

  // Any return to the accepted level restarts the stability window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (btn_sync == db_level) begin
      db_cnt   <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt   <= '0;
      db_level <= btn_sync;
    end else begin
      db_cnt   <= db_cnt + 1'b1;
    end
  end

  assign btn_qual = db_level;
`else
  assign btn_qual = btn_sync;
`endif

  // Release only counts once a genuine low has come through the synchroniser.
  assign low_seen = sync_vld[1] & ~btn_sync & ~btn_qual;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= WAIT_RELEASE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    step       = 1'b0;
    case (state)
      WAIT_PRESS: begin
        if (btn_qual) begin
          state_next = WAIT_RELEASE;
          step       = 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (low_seen) begin
          state_next = WAIT_PRESS;
        end
      end
      default: state_next = WAIT_RELEASE;
    endcase
  end

  always_comb begin
    inc_val      = '0;
    dec_val      = '0;
    load_clamped = '0;
    inc_carry    = 1'b1;
    dec_borrow   = 1'b1;
    digit        = '0;
    ld_digit     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit    = count_bcd[4*i +: 4];
      ld_digit = load_value[4*i +: 4];

      if (inc_carry && digit == 4'd9) begin
        inc_val[4*i +: 4] = 4'd0;
      end else if (inc_carry) begin
        inc_val[4*i +: 4] = digit + 4'd1;
        inc_carry         = 1'b0;
      end else begin
        inc_val[4*i +: 4] = digit;
      end

      if (dec_borrow && digit == 4'd0) begin
        dec_val[4*i +: 4] = 4'd9;
      end else if (dec_borrow) begin
        dec_val[4*i +: 4] = digit - 4'd1;
        dec_borrow        = 1'b0;
      end else begin
        dec_val[4*i +: 4] = digit;
      end

      load_clamped[4*i +: 4] = (ld_digit > 4'd9) ? 4'd9 : ld_digit;
    end
  end

  // A carry (borrow) out of the top digit means every digit is 9 (0).
  assign at_max = inc_carry;
  assign zero   = dec_borrow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_bcd <= START_VALUE;
    end else if (load) begin
      count_bcd <= load_clamped;
    end else if (step) begin
      if (up) begin
        if (WRAP || !at_max) begin
          count_bcd <= inc_val;
        end
      end else begin
        if (WRAP || !zero) begin
          count_bcd <= dec_val;
        end
      end
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    seg = '1;
    for (int i = 0; i < DIGITS; i++) begin
      seg[7*i +: 7] = seg_of(count_bcd[4*i +: 4]);
    end
  end

endmodule
